// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: adds two WORDS*32-bit operands one 32-bit word per
// clock on a single shared ripple-carry adder, LSW first, with a start/busy/done handshake.

module RippleCarryAdder_32bit (
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);
   logic carry_chain;

   always_comb begin
      sum         = '0;
      carry_chain = c_in;
      for (int i = 0; i < 32; i++) begin
         sum[i]      = in1[i] ^ in2[i] ^ carry_chain;
         carry_chain = (in1[i] & in2[i]) | (carry_chain & (in1[i] ^ in2[i]));
      end
      c_out = carry_chain;
   end
endmodule

module multiword_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [32*WORDS-1:0] a,
   input  logic [32*WORDS-1:0] b,
   input  logic                c_in,
   output logic [32*WORDS-1:0] sum,
   output logic                c_out,
   output logic                ovf,
   output logic                busy,
   output logic                done
);
   localparam int N     = 32 * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_reg;
   logic [N-1:0]     a_reg;
   logic [N-1:0]     b_reg;
   logic [N-1:0]     sum_reg;
   logic             carry_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             c_out_reg;
   logic             ovf_reg;

   logic [31:0] a_word [WORDS];
   logic [31:0] b_word [WORDS];

   for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
      assign a_word[gi] = a_reg[gi*32 +: 32];
      assign b_word[gi] = b_reg[gi*32 +: 32];
   end

   // The adder only ever sees registered operands, so host inputs may change after accept.
   logic [31:0] add_sum;
   logic        add_c_out;

   RippleCarryAdder_32bit u_adder (
      .in1   (a_word[idx_reg]),
      .in2   (b_word[idx_reg]),
      .c_in  (carry_reg),
      .sum   (add_sum),
      .c_out (add_c_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         idx_reg   <= '0;
         c_out_reg <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= c_in;
                  idx_reg   <= '0;
                  sum_reg   <= '0;
                  c_out_reg <= 1'b0;
                  ovf_reg   <= 1'b0;
                  state_reg <= S_RUN;
               end else begin
                  state_reg <= S_IDLE;
               end
            end
            S_RUN: begin
               for (int i = 0; i < WORDS; i++) begin
                  if (idx_reg == IDX_W'(i)) begin
                     sum_reg[i*32 +: 32] <= add_sum;
                  end
               end
               carry_reg <= add_c_out;
               idx_reg   <= idx_reg + 1'b1;
               if (idx_reg == LAST_IDX) begin
                  // Signed overflow: operands agree in sign but the result does not.
                  c_out_reg <= add_c_out;
                  ovf_reg   <= (a_reg[N-1] == b_reg[N-1]) && (add_sum[31] != a_reg[N-1]);
                  state_reg <= S_DONE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign sum   = sum_reg;
   assign c_out = c_out_reg;
   assign ovf   = ovf_reg;
   assign busy  = (state_reg == S_RUN);
   assign done  = (state_reg == S_DONE);
endmodule
